// File: rtl/sid_wr_queue_if.sv
// Bus between the port-CF front-end / SID sequencer (master) and the write-posting queue (slave).
interface sid_wr_queue_if #(
   parameter int AW = 3
);
   logic          wr_stb;
   logic [4:0]    wr_addr;
   logic [7:0]    wr_data;
   logic          rd_req;
   logic          rd_grant;
   logic          q_valid;
   logic [4:0]    q_addr;
   logic [7:0]    q_data;
   logic          q_ready;
   logic          flush;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          ovf;
   logic          ovf_clr;

   modport master (
      output wr_stb, wr_addr, wr_data, rd_req, q_ready, flush, ovf_clr,
      input  rd_grant, q_valid, q_addr, q_data, full, empty, level, ovf
   );

   modport slave (
      input  wr_stb, wr_addr, wr_data, rd_req, q_ready, flush, ovf_clr,
      output rd_grant, q_valid, q_addr, q_data, full, empty, level, ovf
   );
endinterface

// File: rtl/sid_wr_queue.sv
// SID write-posting queue: buffers CPU OUTs to port CF, drains them to the bus sequencer and
// holds off CPU INs until every posted write has been issued.
module sid_wr_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic           clk32,
   input  logic           rst_n,
   sid_wr_queue_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, GRANT} state_e;

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            ovf_q, ovf_d;
   logic [12:0]     mem_q [DEPTH];

   logic            is_full, is_empty;
   logic            q_valid, rd_grant;
   logic            do_push, do_pop, drop;

   assign is_full  = (level_q == LVL_FULL);
   assign is_empty = (level_q == '0);

   // A pop frees a slot in the same cycle, so a full queue still takes a write alongside it.
   assign do_pop  = q_valid && bus.q_ready;
   assign do_push = bus.wr_stb && !bus.flush && (!is_full || do_pop);
   assign drop    = bus.wr_stb && !bus.flush && is_full && !do_pop;

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Setting the sticky flag takes priority over a clear in the same cycle.
   assign ovf_d = drop || (ovf_q && !bus.ovf_clr);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the storage is tiny and drives q_addr/q_data directly, so it is reset to keep the
   // head outputs at zero out of reset instead of X.
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
      end
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A write arriving in the same cycle the queue empties postpones the grant.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.rd_req) state_d = DRAIN;
         DRAIN:   if (!bus.rd_req)                      state_d = IDLE;
                  else if (is_empty && !bus.wr_stb)     state_d = GRANT;
         GRANT:   if (!bus.rd_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_grant = (state_q == GRANT);
      q_valid  = !is_empty && (state_q != GRANT);
   end

   assign bus.rd_grant = rd_grant;
   assign bus.q_valid  = q_valid;
   assign bus.q_addr   = mem_q[rd_ptr_q][12:8];
   assign bus.q_data   = mem_q[rd_ptr_q][7:0];
   assign bus.full     = is_full;
   assign bus.empty    = is_empty;
   assign bus.level    = level_q;
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_sid_wr_queue.sv
// Self-checking bench for sid_wr_queue: table-driven cycles with a scoreboard for the head
// entry, plus hand-written reset sequences.
module tb_sid_wr_queue;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   typedef struct {
      logic       wr;
      logic [4:0] a;
      logic [7:0] d;
      logic       rdy;
      logic       rq;
      logic       fl;
      logic       oc;
      int         lvl;
      logic       vld;
      logic       ovf;
      logic       gnt;
   } vec_t;

   logic clk32 = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [12:0] sb[$];
   vec_t        tbl[$];

   sid_wr_queue_if #(.AW(AW)) bus ();

   sid_wr_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk32 (clk32),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk32 = ~clk32;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(logic wr, logic [4:0] a, logic [7:0] d, logic rdy, logic rq,
                               logic fl, logic oc, int lvl, logic vld, logic ovf, logic gnt);
      vec_t v;
      v.wr = wr; v.a = a; v.d = d; v.rdy = rdy; v.rq = rq; v.fl = fl; v.oc = oc;
      v.lvl = lvl; v.vld = vld; v.ovf = ovf; v.gnt = gnt;
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, " level"},    32'(bus.level),  32'd0);
      check({tag, " empty"},    32'(bus.empty),  32'd1);
      check({tag, " full"},     32'(bus.full),   32'd0);
      check({tag, " q_valid"},  32'(bus.q_valid), 32'd0);
      check({tag, " q_addr"},   32'(bus.q_addr), 32'd0);
      check({tag, " q_data"},   32'(bus.q_data), 32'd0);
      check({tag, " rd_grant"}, 32'(bus.rd_grant), 32'd0);
      check({tag, " ovf"},      32'(bus.ovf),    32'd0);
   endtask

   // Called on a falling edge: drive, check the head before the rising edge, check state after.
   task automatic run_vec(input vec_t v, input int idx);
      logic pop;
      logic acc;
      bus.wr_stb  = v.wr;
      bus.wr_addr = v.a;
      bus.wr_data = v.d;
      bus.q_ready = v.rdy;
      bus.rd_req  = v.rq;
      bus.flush   = v.fl;
      bus.ovf_clr = v.oc;
      #1;
      pop = 1'b0;
      if (bus.q_valid) begin
         check($sformatf("v%0d head_expected", idx), 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            check($sformatf("v%0d head", idx), 32'({bus.q_addr, bus.q_data}), 32'(sb[0]));
            pop = v.rdy;
         end
      end
      acc = v.wr && !v.fl && ((sb.size() < DEPTH) || pop);
      if (v.fl) sb.delete();
      else begin
         if (acc) sb.push_back({v.a, v.d});
         if (pop) void'(sb.pop_front());
      end
      @(posedge clk32);
      @(negedge clk32);
      check($sformatf("v%0d level", idx),    32'(bus.level),    32'(v.lvl));
      check($sformatf("v%0d empty", idx),    32'(bus.empty),    32'(v.lvl == 0));
      check($sformatf("v%0d full", idx),     32'(bus.full),     32'(v.lvl == DEPTH));
      check($sformatf("v%0d q_valid", idx),  32'(bus.q_valid),  32'(v.vld));
      check($sformatf("v%0d ovf", idx),      32'(bus.ovf),      32'(v.ovf));
      check($sformatf("v%0d rd_grant", idx), 32'(bus.rd_grant), 32'(v.gnt));
   endtask

   initial begin
      bus.wr_stb = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_req = 1'b0;
      bus.q_ready = 1'b0; bus.flush = 1'b0; bus.ovf_clr = 1'b0;

      // Three writes drained in order, q_valid one clock after the first push.
      tbl.push_back(mk(1, 5'h04, 8'h11, 1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 5'h05, 8'h22, 1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 5'h06, 8'h33, 1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
      // DEPTH+1 writes with no accept: ninth dropped, ovf sticky through the drain.
      for (int i = 0; i <= DEPTH; i++)
         tbl.push_back(mk(1, 5'(8'h10 + i), 8'(8'hA0 + i), 0, 0, 0, 0,
                          (i < DEPTH) ? i + 1 : DEPTH, 1, i == DEPTH, 0));
      for (int i = 0; i < DEPTH; i++)
         tbl.push_back(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, DEPTH - 1 - i, i < DEPTH - 1, 1, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0));
      // Full queue with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++)
         tbl.push_back(mk(1, 5'(i), 8'(8'h50 + i), 0, 0, 0, 0, i + 1, 1, 0, 0));
      tbl.push_back(mk(1, 5'h1A, 8'hC3, 1, 0, 0, 0, DEPTH, 1, 0, 0));
      for (int i = 0; i < DEPTH; i++)
         tbl.push_back(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, DEPTH - 1 - i, i < DEPTH - 1, 0, 0));
      // Read ordering: grant only one clock after the queue empties; pushes held during GRANT.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 5'(8'h08 + i), 8'(8'h60 + i), 0, 0, 0, 0, i + 1, 1, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 5'h00, 8'h00, 1, 1, 0, 0, 3 - i, i < 3, 0, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 5'h1F, 8'hEE, 1, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 5'h00, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 5'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
      // Flush together with a write discards everything, including that write.
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 5'(8'h0C + i), 8'(8'h70 + i), 0, 0, 0, 0, i + 1, 1, 0, 0));
      tbl.push_back(mk(1, 5'h02, 8'h99, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5'h07, 8'h77, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
      // Enter GRANT on an empty queue, then post five writes while granted.
      tbl.push_back(mk(0, 5'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 5'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 5'(8'h13 + i), 8'(8'h80 + i), 0, 1, 0, 0, i + 1, 0, 0, 1));

      #2;
      check_reset_values("por");
      @(negedge clk32);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Asynchronous reset mid-cycle while granted with five entries held.
      check("pre_rst level", 32'(bus.level), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async");
      sb.delete();
      bus.wr_stb = 1'b0; bus.rd_req = 1'b0; bus.q_ready = 1'b0;
      @(negedge clk32);
      check_reset_values("held");
      rst_n = 1'b1;
      run_vec(mk(1, 5'h03, 8'h44, 0, 0, 0, 0, 1, 1, 0, 0), 1000);
      run_vec(mk(0, 5'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0), 1001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
